key_conditioner: RTL and testbench

Input conditioning stage directly upstream of the bomb-game top level. It takes the raw board pushbuttons (BTN1, BTN6) and slide switches (SW7, SW[6:0]) and produces the clean signals that the control and password-input logic consume. Each channel is synchronised and debounced, and the block adds single-cycle press pulses, long-press detection and a switch-change strobe. This removes the need for downstream FSMs to tolerate bounce or metastability.

---
 rtl/key_conditioner.sv | 213 +++++++++++++++++++++
 tb/tb_key_conditioner.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
//
// Input conditioning for the bomb-game board controls. Each raw pushbutton and
// slide switch is brought into the clk domain through a two-flop synchroniser.
// It is then debounced with a per-channel stability counter. The block also
// derives a single-cycle press strobe and a single-cycle long-press strobe for
// each button, plus one change strobe shared by all switches.
//
// Parameters
//   DB_CYCLES    consecutive stable synchronised cycles before a level moves (>= 2)
//   LONG_CYCLES  cycles of debounced hold before the long-press strobe (> DB_CYCLES)
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   BTN1, BTN6  raw active-high buttons (asynchronous)
//   SW7, SW     raw slide switches (asynchronous)
//   btn1_lvl, btn6_lvl      debounced button levels
//   btn1_pulse, btn6_pulse  one-cycle strobe in the first cycle a button level reads 1
//   btn1_long, btn6_long    one-cycle strobe after LONG_CYCLES cycles of hold
//   sw7_lvl, sw_lvl         debounced switch levels
//   sw_chg                  one-cycle strobe, the cycle after any switch level changed
//
// Channel order inside the vectors: 0 BTN1, 1 BTN6, 2 SW7, 3..9 SW[0..6].
module key_conditioner #(
  parameter int DB_CYCLES   = 20000,
  parameter int LONG_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BTN1,
  input  logic       BTN6,
  input  logic       SW7,
  input  logic [6:0] SW,
  output logic       btn1_lvl,
  output logic       btn6_lvl,
  output logic       btn1_pulse,
  output logic       btn6_pulse,
  output logic       btn1_long,
  output logic       btn6_long,
  output logic       sw7_lvl,
  output logic [6:0] sw_lvl,
  output logic       sw_chg
);

  localparam int NCH    = 10;
  localparam int NBTN   = 2;
  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FIRED = 2'd2
  } hold_state_t;

  function automatic logic [DB_W-1:0] db_sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_LAST) ? v : v + 1'b1;
  endfunction

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  sync_p0;
  logic [NCH-1:0]  sync_p1;
  logic [NCH-1:0]  lvl_p2;
  logic [NCH-1:0]  lvl_nxt;
  logic [DB_W-1:0] db_cnt_p2  [NCH];
  logic [DB_W-1:0] db_cnt_nxt [NCH];

  logic [NBTN-1:0] press_p2;
  logic [7:0]      sw_prev_p3;
  logic            sw_chg_p3;

  hold_state_t     hold_st      [NBTN];
  hold_state_t     hold_st_nxt  [NBTN];
  logic [HOLD_W-1:0] hold_cnt     [NBTN];
  logic [HOLD_W-1:0] hold_cnt_nxt [NBTN];
  logic [NBTN-1:0] long_nxt;
  logic [NBTN-1:0] long_p2;

  assign raw = {SW, SW7, BTN6, BTN1};

  // Stage p0/p1: two-flop synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce. The counter only advances while the synchronised value
  // disagrees with the held level; any agreement restarts it from zero.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lvl_nxt[i]    = lvl_p2[i];
      db_cnt_nxt[i] = '0;
      if (sync_p1[i] != lvl_p2[i]) begin
        if (db_cnt_p2[i] == DB_LAST) begin
          lvl_nxt[i] = ~lvl_p2[i];
        end else begin
          db_cnt_nxt[i] = db_sat_inc(db_cnt_p2[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_p2   <= '0;
      press_p2 <= '0;
      for (int i = 0; i < NCH; i++) begin
        db_cnt_p2[i] <= '0;
      end
    end else begin
      lvl_p2   <= lvl_nxt;
      // Registered alongside the level so the strobe lines up with its first 1 cycle.
      press_p2 <= lvl_nxt[NBTN-1:0] & ~lvl_p2[NBTN-1:0];
      for (int i = 0; i < NCH; i++) begin
        db_cnt_p2[i] <= db_cnt_nxt[i];
      end
    end
  end

  // Long-press FSM, one per button. It follows the next-state level so that the
  // hold count is aligned with the cycles in which the registered level reads 1:
  // the count is 0 in the first such cycle and the strobe lands in cycle LONG_CYCLES.
  always_comb begin
    for (int b = 0; b < NBTN; b++) begin
      hold_st_nxt[b]  = hold_st[b];
      hold_cnt_nxt[b] = hold_cnt[b];
      long_nxt[b]     = 1'b0;
      case (hold_st[b])
        IDLE: begin
          if (lvl_nxt[b]) begin
            hold_st_nxt[b]  = HELD;
            hold_cnt_nxt[b] = '0;
          end
        end
        HELD: begin
          if (!lvl_nxt[b]) begin
            hold_st_nxt[b]  = IDLE;
            hold_cnt_nxt[b] = '0;
          end else begin
            hold_cnt_nxt[b] = hold_sat_inc(hold_cnt[b]);
            if (hold_cnt[b] == HOLD_PRE) begin
              long_nxt[b]    = 1'b1;
              hold_st_nxt[b] = FIRED;
            end
          end
        end
        FIRED: begin
          if (!lvl_nxt[b]) begin
            hold_st_nxt[b]  = IDLE;
            hold_cnt_nxt[b] = '0;
          end
        end
        default: begin
          hold_st_nxt[b]  = IDLE;
          hold_cnt_nxt[b] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_p2 <= '0;
      for (int b = 0; b < NBTN; b++) begin
        hold_st[b]  <= IDLE;
        hold_cnt[b] <= '0;
      end
    end else begin
      long_p2 <= long_nxt;
      for (int b = 0; b < NBTN; b++) begin
        hold_st[b]  <= hold_st_nxt[b];
        hold_cnt[b] <= hold_cnt_nxt[b];
      end
    end
  end

  // Stage p3: switch change strobe, one cycle after the level edge; several
  // simultaneous toggles collapse into one strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_prev_p3 <= '0;
      sw_chg_p3  <= 1'b0;
    end else begin
      sw_prev_p3 <= lvl_p2[NCH-1:NBTN];
      sw_chg_p3  <= |(lvl_p2[NCH-1:NBTN] ^ sw_prev_p3);
    end
  end

  assign btn1_lvl   = lvl_p2[0];
  assign btn6_lvl   = lvl_p2[1];
  assign btn1_pulse = press_p2[0];
  assign btn6_pulse = press_p2[1];
  assign btn1_long  = long_p2[0];
  assign btn6_long  = long_p2[1];
  assign sw7_lvl    = lvl_p2[2];
  assign sw_lvl     = lvl_p2[9:3];
  assign sw_chg     = sw_chg_p3;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;
  localparam int DB = 4;
  localparam int LG = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BTN1, BTN6, SW7;
  logic [6:0] SW;
  logic       btn1_lvl, btn6_lvl, btn1_pulse, btn6_pulse;
  logic       btn1_long, btn6_long, sw7_lvl, sw_chg;
  logic [6:0] sw_lvl;

  int n_vec = 0;
  int n_err = 0;

  key_conditioner #(.DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk(clk), .rst_n(rst_n), .BTN1(BTN1), .BTN6(BTN6), .SW7(SW7), .SW(SW),
    .btn1_lvl(btn1_lvl), .btn6_lvl(btn6_lvl), .btn1_pulse(btn1_pulse),
    .btn6_pulse(btn6_pulse), .btn1_long(btn1_long), .btn6_long(btn6_long),
    .sw7_lvl(sw7_lvl), .sw_lvl(sw_lvl), .sw_chg(sw_chg)
  );

  always #5 clk = ~clk;

  // Reference model. Channel order: 0 BTN1, 1 BTN6, 2 SW7, 3..9 SW[0..6].
  // samp[0] is the raw vector sampled at the latest edge, samp[k] k edges earlier.
  // A level flips once the synchronised value has disagreed with it for the
  // DB cycles before an edge, i.e. raw samples taken 2..DB+1 edges back.
  logic [9:0] samp [0:DB];
  logic [9:0] m_lvl;
  logic [1:0] m_pulse, m_long;
  logic       m_chg, m_tog;
  int         hi_cnt [2];
  int         edge_no = 0;

  task automatic model_edge();
    logic [9:0] raw, nl;
    bit diff;
    raw = {SW, SW7, BTN6, BTN1};
    edge_no++;
    if (!rst_n) begin
      for (int k = 0; k <= DB; k++) samp[k] = '0;
      m_lvl = '0; m_pulse = '0; m_long = '0; m_chg = 1'b0; m_tog = 1'b0;
      hi_cnt[0] = 0; hi_cnt[1] = 0;
    end else begin
      nl = m_lvl;
      for (int c = 0; c < 10; c++) begin
        diff = 1'b1;
        for (int k = 1; k <= DB; k++) if (samp[k][c] == m_lvl[c]) diff = 1'b0;
        if (diff) nl[c] = ~m_lvl[c];
      end
      for (int k = DB; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = raw;
      m_chg   = m_tog;
      m_tog   = |(nl[9:2] ^ m_lvl[9:2]);
      m_pulse = nl[1:0] & ~m_lvl[1:0];
      for (int b = 0; b < 2; b++) begin
        // hi_cnt = number of cycles the level has read 1, counting the first as 1
        hi_cnt[b] = nl[b] ? ((hi_cnt[b] < 100000) ? hi_cnt[b] + 1 : hi_cnt[b]) : 0;
        m_long[b] = (hi_cnt[b] == LG);
      end
      m_lvl = nl;
    end
  endtask

  function automatic logic [14:0] exp_vec();
    return {m_lvl[0], m_lvl[1], m_pulse[0], m_pulse[1], m_long[0], m_long[1],
            m_lvl[2], m_lvl[9:3], m_chg};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {btn1_lvl, btn6_lvl, btn1_pulse, btn6_pulse, btn1_long, btn6_long,
            sw7_lvl, sw_lvl, sw_chg};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== 15'd0) begin
        n_err++; $display("FAIL reset_state edge=%0d got=%h exp=%h", edge_no, dut_vec(), 15'd0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_idle edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_btn1_press();
    int rise_at, fall_at, pulses, rel_pulses;
    rise_at = -1; fall_at = -1; pulses = 0; rel_pulses = 0;
    BTN1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL btn1_press edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (btn1_lvl && rise_at < 0) rise_at = i;
      if (btn1_pulse) pulses++;
    end
    n_vec++;
    if (rise_at != DB + 2) begin
      n_err++; $display("FAIL btn1_rise_latency got=%0d exp=%0d", rise_at, DB + 2);
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL btn1_pulse_count got=%0d exp=1", pulses);
    end
    BTN1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL btn1_release edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (!btn1_lvl && fall_at < 0) fall_at = i;
      if (btn1_pulse) rel_pulses++;
    end
    n_vec++;
    if (fall_at != DB + 2) begin
      n_err++; $display("FAIL btn1_fall_latency got=%0d exp=%0d", fall_at, DB + 2);
    end
    n_vec++;
    if (rel_pulses != 0) begin
      n_err++; $display("FAIL btn1_release_pulse got=%0d exp=0", rel_pulses);
    end
  endtask

  task automatic test_btn6_bounce();
    logic [8:0] pat;
    int rise_at, pulses, drops;
    pat = 9'b111101101;  // bit i driven in cycle i: 1,0,1,1,0,1,1,1,1
    rise_at = -1; pulses = 0; drops = 0;
    for (int i = 1; i <= 14; i++) begin
      BTN6 = (i <= 9) ? pat[i-1] : 1'b1;
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL btn6_bounce edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (btn6_lvl && rise_at < 0) rise_at = i;
      if (btn6_pulse) pulses++;
    end
    // last 0 sampled at edge 5, stable 1s from edge 6: four s2 cycles end at edge 11
    n_vec++;
    if (rise_at != 11) begin
      n_err++; $display("FAIL btn6_bounce_rise got=%0d exp=11", rise_at);
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL btn6_pulse_count got=%0d exp=1", pulses);
    end
    for (int i = 1; i <= 11; i++) begin
      BTN6 = (i <= 3) ? 1'b0 : 1'b1;
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL btn6_glitch edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (!btn6_lvl) drops++;
    end
    n_vec++;
    if (drops != 0) begin
      n_err++; $display("FAIL btn6_glitch_pass got=%0d exp=0", drops);
    end
    BTN6 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL btn6_release edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_long_press();
    int hi, long_at, longs;
    for (int rep = 0; rep < 2; rep++) begin
      hi = 0; long_at = -1; longs = 0;
      BTN1 = 1'b1;
      for (int i = 0; i < ((rep == 0) ? 30 : 18); i++) begin
        step();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL long_hold edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
        end
        if (btn1_lvl) hi++;
        if (btn1_long) begin longs++; long_at = hi; end
      end
      n_vec++;
      if (longs != 1) begin
        n_err++; $display("FAIL long_count rep=%0d got=%0d exp=1", rep, longs);
      end
      n_vec++;
      if (long_at != LG) begin
        n_err++; $display("FAIL long_position rep=%0d got=%0d exp=%0d", rep, long_at, LG);
      end
      BTN1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        step();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL long_release edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_switches();
    int sw2_at, sw7_at, chg_at, chg_n, chg_n2;
    sw2_at = -1; sw7_at = -1; chg_at = -1; chg_n = 0; chg_n2 = 0;
    SW[2] = 1'b1; SW7 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL sw_flip edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (sw_lvl[2] && sw2_at < 0) sw2_at = i;
      if (sw7_lvl && sw7_at < 0) sw7_at = i;
      if (sw_chg) begin chg_n++; chg_at = i; end
    end
    n_vec++;
    if (sw2_at != DB + 2 || sw7_at != DB + 2) begin
      n_err++; $display("FAIL sw_same_edge got=%0d/%0d exp=%0d", sw2_at, sw7_at, DB + 2);
    end
    n_vec++;
    if (chg_n != 1 || chg_at != DB + 3) begin
      n_err++; $display("FAIL sw_chg_once got=%0d@%0d exp=1@%0d", chg_n, chg_at, DB + 3);
    end
    SW = 7'b1010101;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL sw_pattern edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (sw_chg) chg_n2++;
    end
    n_vec++;
    if (sw_lvl !== 7'b1010101) begin
      n_err++; $display("FAIL sw_settle got=%b exp=%b", sw_lvl, 7'b1010101);
    end
    n_vec++;
    if (chg_n2 != 1) begin
      n_err++; $display("FAIL sw_multi_chg got=%0d exp=1", chg_n2);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit found;
    int rise_at, pulse_at, long_at;
    found = 1'b0;
    BTN1 = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL mid_press edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (btn1_lvl) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL mid_rise_timeout got=0 exp=1");
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL mid_hold edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b0;
    step();
    n_vec++;
    if (dut_vec() !== 15'd0) begin
      n_err++; $display("FAIL mid_reset_clear got=%h exp=%h", dut_vec(), 15'd0);
    end
    rst_n = 1'b1;
    rise_at = -1; pulse_at = -1; long_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL mid_recover edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
      if (btn1_lvl && rise_at < 0) rise_at = i;
      if (btn1_pulse) pulse_at = i;
      if (btn1_long) long_at = i;
    end
    n_vec++;
    if (rise_at != DB + 2 || pulse_at != DB + 2) begin
      n_err++; $display("FAIL mid_reassert got=%0d/%0d exp=%0d", rise_at, pulse_at, DB + 2);
    end
    n_vec++;
    if (long_at != DB + 2 + LG - 1) begin
      n_err++; $display("FAIL mid_long got=%0d exp=%0d", long_at, DB + 2 + LG - 1);
    end
    BTN1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL mid_release edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [9:0] r;
    for (int seg = 0; seg < 120; seg++) begin
      r = 10'($urandom);
      {SW, SW7} = r[9:2];
      if ($urandom_range(0, 2) == 0) {BTN6, BTN1} = r[1:0];
      rst_n = ($urandom_range(0, 29) != 0);
      hold = rst_n ? int'($urandom_range(1, 14)) : 1;
      for (int i = 0; i < hold; i++) begin
        step();
        n_vec++;
        if (dut_vec() !== exp_vec()) begin
          n_err++; $display("FAIL random edge=%0d got=%h exp=%h", edge_no, dut_vec(), exp_vec());
        end
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; BTN1 = 1'b0; BTN6 = 1'b0; SW7 = 1'b0; SW = '0;
    for (int k = 0; k <= DB; k++) samp[k] = '0;
    m_lvl = '0; m_pulse = '0; m_long = '0; m_chg = 1'b0; m_tog = 1'b0;
    hi_cnt[0] = 0; hi_cnt[1] = 0;
    test_reset();
    test_btn1_press();
    test_btn6_bounce();
    test_long_press();
    test_switches();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
